// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and shift-amount width for the execute-stage ALU.
// Imported by alu_exec_unit and alu_mul_iter.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_MUL  = 4'h2;
  localparam logic [3:0] ALU_SLL  = 4'h3;
  localparam logic [3:0] ALU_SLT  = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_OR   = 4'h7;
  localparam logic [3:0] ALU_AND  = 4'h8;
  localparam logic [3:0] ALU_SLLI = 4'h9;
  localparam logic [3:0] ALU_SRLI = 4'hA;

  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles after load.
// o_last flags the final iteration; o_product is the accumulator including that iteration.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_run;

  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  // Final sum is exposed combinationally so the top can capture it on the last iteration edge.
  assign o_last     = r_run && (r_cnt == CW'(WIDTH - 1));
  assign o_product  = w_acc_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (i_load) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (o_last) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops done one cycle after accept; mult iterates WIDTH cycles with o_busy high.
// Define ALU_FAST_MULT_EN for a single-cycle multiply (no MUL state, o_busy tied 0).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_alu_operation,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_done,
  output logic             o_busy
);

  alu_state_t       r_state;
  alu_state_t       w_next;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic             w_accept;
  logic             w_is_iter;
  logic [WIDTH-1:0] w_alu_res;
  logic [SHAMT_W-1:0] w_shamt;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_mul_prod;

  assign w_shamt  = i_op_b[SHAMT_W-1:0];
  assign w_accept = i_start && (r_state != ST_MUL);

`ifdef ALU_FAST_MULT_EN
  assign w_is_iter  = 1'b0;
  assign w_mul_last = 1'b0;
  assign w_mul_prod = '0;
`else
  assign w_is_iter = (i_alu_operation == ALU_MUL);

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul_iter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_accept && w_is_iter),
    .i_a       (i_op_a),
    .i_b       (i_op_b),
    .o_last    (w_mul_last),
    .o_product (w_mul_prod)
  );
`endif

  always_comb begin
    w_alu_res = '0;
    case (i_alu_operation)
      ALU_ADD:            w_alu_res = i_op_a + i_op_b;
      ALU_SUB:            w_alu_res = i_op_a - i_op_b;
`ifdef ALU_FAST_MULT_EN
      ALU_MUL:            w_alu_res = i_op_a * i_op_b;
`endif
      ALU_SLL, ALU_SLLI:  w_alu_res = i_op_a << w_shamt;
      ALU_SLT:            w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      ALU_XOR:            w_alu_res = i_op_a ^ i_op_b;
      ALU_SRL, ALU_SRLI:  w_alu_res = i_op_a >> w_shamt;
      ALU_OR:             w_alu_res = i_op_a | i_op_b;
      ALU_AND:            w_alu_res = i_op_a & i_op_b;
      default:            w_alu_res = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      ST_MUL: begin
        o_busy = 1'b1;
        if (w_mul_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done = 1'b1;
        if (i_start) begin
          w_next = w_is_iter ? ST_MUL : ST_DONE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        if (i_start) begin
          w_next = w_is_iter ? ST_MUL : ST_DONE;
        end else begin
          w_next = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_accept && !w_is_iter) begin
        r_result <= w_alu_res;
        r_zero   <= (w_alu_res == '0);
      end else if ((r_state == ST_MUL) && w_mul_last) begin
        r_result <= w_mul_prod;
        r_zero   <= (w_mul_prod == '0);
      end
    end
  end

  assign o_result = r_result;
  assign o_zero   = r_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are queued at issue, a negedge monitor checks each o_done.
module tb_alu_exec_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [3:0]  i_alu_operation;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic [31:0] o_result;
  logic        o_zero;
  logic        o_done;
  logic        o_busy;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  alu_exec_unit #(.WIDTH(32)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_start         (i_start),
    .i_alu_operation (i_alu_operation),
    .i_op_a          (i_op_a),
    .i_op_b          (i_op_b),
    .o_result        (o_result),
    .o_zero          (o_zero),
    .o_done          (o_done),
    .o_busy          (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Monitor: pops one expected value for every done pulse
  always @(negedge i_clk) begin
    if (!i_rst && o_done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done result=%h (no operation outstanding)", o_result);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        tests++;
        if (o_result !== e) begin
          fails++;
          $display("FAIL result got=%h exp=%h", o_result, e);
        end
        tests++;
        if (o_zero !== (e == 32'h0)) begin
          fails++;
          $display("FAIL zero_flag got=%b exp=%b (result exp=%h)", o_zero, (e == 32'h0), e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called #1 after a rising edge; the start is accepted at the next rising edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push);
    if (push) exp_q.push_back(exp);
    i_start         = 1'b1;
    i_alu_operation = op;
    i_op_a          = a;
    i_op_b          = b;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_op_a  = 32'hDEAD_BEEF;
    i_op_b  = 32'hCAFE_F00D;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, o_result, 32'h0);
    check({tag, "_zero"}, {31'h0, o_zero}, 32'h1);
    check({tag, "_done"}, {31'h0, o_done}, 32'h0);
    check({tag, "_busy"}, {31'h0, o_busy}, 32'h0);
  endtask

  // Waits for o_done after a mult accept, counting busy cycles; injects an ignored start mid-way.
  task automatic run_mult(input string tag);
    int n;
    int busy_cnt;
    int done_at;
    busy_cnt = 0;
    done_at  = 0;
    for (n = 1; n <= 40; n++) begin
      @(negedge i_clk);
      if (n == 5) begin
        i_start = 1'b1; i_alu_operation = 4'h0; i_op_a = 32'h1; i_op_b = 32'h1;
      end else if (n == 6) begin
        i_start = 1'b0;
      end
      if (o_done) begin
        done_at = n;
        break;
      end
      if (o_busy) busy_cnt++;
    end
    i_start = 1'b0;
`ifdef ALU_FAST_MULT_EN
    check({tag, "_busy_cycles"}, busy_cnt, 0);
    check({tag, "_done_cycle"}, done_at, 1);
`else
    check({tag, "_busy_cycles"}, busy_cnt, 32);
    check({tag, "_done_cycle"}, done_at, 33);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_alu_operation = 4'h0;
    i_op_a = 32'h0;
    i_op_b = 32'h0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Back-to-back single-cycle vectors
    issue(4'h1, 32'd5,          32'd5,          32'h0000_0000, 1);
    issue(4'h0, 32'd2,          32'd3,          32'h0000_0005, 1);
    issue(4'h4, 32'hFFFF_FFFF,  32'd1,          32'h0000_0001, 1);
    issue(4'h4, 32'd1,          32'hFFFF_FFFF,  32'h0000_0000, 1);
    issue(4'h6, 32'h8000_0000,  32'h0000_0021,  32'h4000_0000, 1);
    issue(4'h3, 32'h0000_0001,  32'd31,         32'h8000_0000, 1);
    issue(4'h9, 32'h0000_0003,  32'h0000_0024,  32'h0000_0030, 1);
    issue(4'hA, 32'h0000_00F0,  32'd4,          32'h0000_000F, 1);
    issue(4'h5, 32'hFF00_FF00,  32'h0FF0_0FF0,  32'hF0F0_F0F0, 1);
    issue(4'h7, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF, 1);
    issue(4'h8, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000, 1);
    issue(4'hB, 32'h1234_5678,  32'h1111_1111,  32'h0000_0000, 1);
    issue(4'h0, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1);
    issue(4'h1, 32'd0,          32'd1,          32'hFFFF_FFFF, 1);
    repeat (2) @(posedge i_clk);
    #1;

    issue(4'h2, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1);
    run_mult("mult_neg1x3");
    @(posedge i_clk); #1;
    issue(4'h2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1);
    run_mult("mult_overflow");
    @(posedge i_clk); #1;
    issue(4'h2, 32'd7, 32'd6, 32'd42, 1);
    run_mult("mult_7x6");
    @(posedge i_clk); #1;

    // Abort a multiply after 10 iterations; no done may follow
    issue(4'h2, 32'd5, 32'd7, 32'd35, 0);
`ifndef ALU_FAST_MULT_EN
    repeat (9) @(posedge i_clk);
    #1;
    check("busy_before_abort", {31'h0, o_busy}, 32'h1);
`endif
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check_reset_outputs("abort");
    dones = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_done) dones++;
    end
    check("abort_no_done", dones, 0);
    @(posedge i_clk); #1;
    issue(4'h0, 32'd2, 32'd3, 32'd5, 1);

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
